// File: rtl/shared_adder_pkg.sv
// Shared types and helpers for the time-shared extend-and-add unit.
// Optional overflow flag output is enabled with SHARED_ADDER_OVF_EN.
package shared_adder_pkg;

  localparam int XW = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic [6:0]    len_t;
  typedef logic [XW-1:0] xv_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ost_t;

  // keep len LSBs, fill above with the top kept bit (signed) or zero
  function automatic xv_t ext_to(xv_t value, len_t len, logic sgn);
    xv_t  r;
    logic fill;
    r    = '0;
    fill = 1'b0;
    if (len != '0) begin
      fill = sgn & value[len[5:0] - 6'd1];
      for (int i = 0; i < XW; i++)
        r[i] = (i < int'(len)) ? value[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_adder_sched_rr_arbiter.sv
// Round-robin arbiter with one-hot grant and a rotating start pointer.
// Pointer moves past the winner on every grant and holds otherwise.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx,
  output logic          any
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  // scan upward from the pointer with wrap, first requester wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (advance && !any && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        any        = 1'b1;
      end
    end
    ptr_nxt = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (any)
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/shared_adder_sched.sv
// Arbitrated extend / add-sub / re-extend datapath with one output register.
// Define SHARED_ADDER_OVF_EN to add the registered resp_ovf output.
module shared_adder_sched
  import shared_adder_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 16,
  localparam int LW    = $clog2(W + 1),
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*W-1:0]  req_a,
  input  logic [N_REQ*W-1:0]  req_b,
  input  logic [N_REQ*LW-1:0] req_a_len,
  input  logic [N_REQ*LW-1:0] req_b_len,
  input  logic [N_REQ*LW-1:0] req_res_len,
  input  logic [N_REQ-1:0]    req_signed,
  input  logic [N_REQ-1:0]    req_sub,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IW-1:0]       resp_id,
  output logic [W-1:0]        resp_data
`ifdef SHARED_ADDER_OVF_EN
  ,
  output logic                resp_ovf
`endif
);

  localparam int            W1 = W + 1;
  localparam logic [LW-1:0] WL = LW'(W);

  function automatic len_t clampl(logic [LW-1:0] l);
    return (l > WL) ? len_t'(W) : len_t'(l);
  endfunction

  ost_t          st;
  ost_t          st_nxt;
  logic          free;
  logic          any;
  logic [IW-1:0] gidx;
  logic [W-1:0]  a_s;
  logic [W-1:0]  b_s;
  logic [LW-1:0] al;
  logic [LW-1:0] bl;
  logic [LW-1:0] rl;
  logic          sgn;
  logic          sub;
  logic [W:0]    oa;
  logic [W:0]    ob;
  logic [W:0]    raw;
  logic [W-1:0]  res;

  assign free = (st == EMPTY) || resp_ready;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (free && !rst),
    .grant   (req_ready),
    .gidx    (gidx),
    .any     (any)
  );

  // select the granted request and run extend, add/sub, re-extend
  always_comb begin
    a_s = req_a[int'(gidx)*W +: W];
    b_s = req_b[int'(gidx)*W +: W];
    al  = req_a_len[int'(gidx)*LW +: LW];
    bl  = req_b_len[int'(gidx)*LW +: LW];
    rl  = req_res_len[int'(gidx)*LW +: LW];
    sgn = req_signed[gidx];
    sub = req_sub[gidx];
    oa  = W1'(ext_to(xv_t'(a_s), clampl(al), sgn));
    ob  = W1'(ext_to(xv_t'(b_s), clampl(bl), sgn));
    raw = (sub == OP_SUB) ? oa - ob : oa + ob;
    res = W'(ext_to(xv_t'(raw), clampl(rl), sgn));
  end

  // output stage state register
  always_ff @(posedge clk) begin
    if (rst)
      st <= EMPTY;
    else
      st <= st_nxt;
  end

  // fill on a grant, drain when the consumer takes the result
  always_comb begin
    st_nxt = st;
    if (any)
      st_nxt = FULL;
    else if (resp_ready)
      st_nxt = EMPTY;
  end

  // output decode
  always_comb begin
    resp_valid = (st == FULL);
  end

  // result payload register, loaded on every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id   <= '0;
      resp_data <= '0;
    end else if (any) begin
      resp_id   <= gidx;
      resp_data <= res;
    end
  end

`ifdef SHARED_ADDER_OVF_EN
  logic [W:0] rfit;
  logic       ovf;

  // raw result survives re-extension only if it fits in res_len bits
  always_comb begin
    rfit = W1'(ext_to(xv_t'(raw), clampl(rl), sgn));
    ovf  = (rfit != raw);
  end

  // overflow flag travels with the data
  always_ff @(posedge clk) begin
    if (rst)
      resp_ovf <= 1'b0;
    else if (any)
      resp_ovf <= ovf;
  end
`endif

endmodule
